// File: rtl/rect_fill_ctrl.sv
// -----------------------------------------------------------------------------
// rect_fill_ctrl
//   Fills an axis-aligned rectangle (or the whole screen) with a single colour
//   by emitting one pixel write per clock towards a VGA adapter, in raster
//   order. The rectangle is clipped against the visible screen, so no write
//   ever lands outside SCREEN_W x SCREEN_H.
//
// Parameters
//   SCREEN_W   visible pixel columns
//   SCREEN_H   visible pixel rows
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   fill the rectangle x0/y0/w/h (sampled in IDLE only)
//   clear      in   fill the whole screen (wins over start)
//   x0, y0     in   rectangle top-left corner
//   w, h       in   rectangle size in pixels
//   colour_in  in   fill colour {R,G,B}
//   x, y       out  current pixel coordinate
//   colour     out  current pixel colour
//   plot       out  pixel write strobe, one pixel per high cycle
//   busy       out  high from LOAD through FINISH
//   done       out  one-cycle pulse when a fill completes
// -----------------------------------------------------------------------------
module rect_fill_ctrl #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);

  state_t     state, state_nxt;

  // Request captured in IDLE; the fill works only from these copies so that
  // the inputs may change freely once the request has been taken.
  logic [7:0] x0_l, w_l;
  logic [6:0] y0_l, h_l;
  logic [2:0] col_l;

  // Inclusive clipped end coordinates, kept 9 bits wide like the sums.
  logic [8:0] xe, ye;

  logic [8:0] x_sum, y_sum, xe_calc, ye_calc;
  logic       empty, x_last, y_last;

  // 9-bit sums cannot overflow (255+255 < 512), so min() then -1 is exact.
  assign x_sum   = {1'b0, x0_l} + {1'b0, w_l};
  assign y_sum   = {2'b0, y0_l} + {2'b0, h_l};
  assign xe_calc = ((x_sum > SW9) ? SW9 : x_sum) - 9'd1;
  assign ye_calc = ((y_sum > SH9) ? SH9 : y_sum) - 9'd1;

  // Nothing visible to draw: zero size or origin already off screen.
  assign empty = (w_l == 8'd0) || (h_l == 7'd0) ||
                 ({1'b0, x0_l} >= SW9) || ({2'b0, y0_l} >= SH9);

  assign x_last = ({1'b0, x} == xe);
  assign y_last = ({2'b0, y} == ye);

  assign colour = col_l;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    plot      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (clear || start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = empty ? FINISH : DRAW;
      end
      DRAW: begin
        plot = 1'b1;
        if (x_last && y_last) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x0_l  <= '0;
      y0_l  <= '0;
      w_l   <= '0;
      h_l   <= '0;
      col_l <= '0;
      xe    <= '0;
      ye    <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            x0_l  <= '0;
            y0_l  <= '0;
            w_l   <= 8'(SCREEN_W);
            h_l   <= 7'(SCREEN_H);
            col_l <= colour_in;
          end else if (start) begin
            x0_l  <= x0;
            y0_l  <= y0;
            w_l   <= w;
            h_l   <= h;
            col_l <= colour_in;
          end
        end
        LOAD: begin
          xe <= xe_calc;
          ye <= ye_calc;
          x  <= x0_l;
          y  <= y0_l;
        end
        DRAW: begin
          // Raster scan: wrap x back to the left edge at the end of a row.
          if (x_last) begin
            x <= x0_l;
            if (!y_last) y <= y + 7'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
module tb_rect_fill_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       start, clear;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_total = 0;
  int n_pass  = 0;

  rect_fill_ctrl #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .clear    (clear),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .colour_in(colour_in),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Issue one request and follow the whole fill cycle by cycle against a
  // reference built from the requested rectangle and a 160x120 screen.
  task automatic do_fill(input string tag, input bit use_clear, input bit use_start,
                         input int ax0, input int ay0, input int aw, input int ah,
                         input int col, input int poke_at);
    int ex0, ey0, ew, eh, xe, ye, cols, npix, errs, px, py;
    bit empty;
    if (use_clear) begin
      ex0 = 0; ey0 = 0; ew = 160; eh = 120;
    end else begin
      ex0 = ax0; ey0 = ay0; ew = aw; eh = ah;
    end
    empty = (ew == 0) || (eh == 0) || (ex0 >= 160) || (ey0 >= 120);
    xe    = ((ex0 + ew) < 160 ? ex0 + ew : 160) - 1;
    ye    = ((ey0 + eh) < 120 ? ey0 + eh : 120) - 1;
    cols  = empty ? 0 : xe - ex0 + 1;
    npix  = empty ? 0 : cols * (ye - ey0 + 1);

    @(negedge CLOCK_50);
    start = use_start; clear = use_clear;
    x0 = ax0[7:0]; y0 = ay0[6:0]; w = aw[7:0]; h = ah[6:0]; colour_in = col[2:0];

    // LOAD cycle: scramble inputs to show they no longer matter.
    @(negedge CLOCK_50);
    start = 1'b0; clear = 1'b0;
    x0 = 8'd77; y0 = 7'd33; w = 8'd1; h = 7'd1; colour_in = ~col[2:0];
    chk({tag, "_load_busy"}, 32'(busy), 1);
    chk({tag, "_load_plot"}, 32'(plot), 0);

    errs = 0;
    for (int k = 0; k < npix; k++) begin
      @(negedge CLOCK_50);
      px = ex0 + (k % cols);
      py = ey0 + (k / cols);
      if (npix <= 64) begin
        chk($sformatf("%s_p%0d_plot", tag, k), 32'(plot), 1);
        chk($sformatf("%s_p%0d_x", tag, k), 32'(x), px);
        chk($sformatf("%s_p%0d_y", tag, k), 32'(y), py);
        chk($sformatf("%s_p%0d_col", tag, k), 32'(colour), col);
      end else begin
        if (plot !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            32'(x) != px || 32'(y) != py || 32'(colour) != col) errs++;
      end
      start = (k == poke_at) ? 1'b1 : 1'b0;
    end
    if (npix > 64) chk({tag, "_pixels"}, errs, 0);

    @(negedge CLOCK_50);
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_fin_plot"}, 32'(plot), 0);
    chk({tag, "_fin_busy"}, 32'(busy), 1);

    @(negedge CLOCK_50);
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);

    errs = 0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk({tag, "_quiet"}, errs, 0);
  endtask

  initial begin
    int errs;
    resetn = 1'b0; start = 1'b0; clear = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
    #1;
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    do_fill("rect", 1'b0, 1'b1, 10, 5, 3, 2, 4, -1);
    do_fill("clr", 1'b1, 1'b0, 0, 0, 0, 0, 0, -1);
    do_fill("corner", 1'b0, 1'b1, 158, 118, 5, 5, 5, -1);
    do_fill("w0", 1'b0, 1'b1, 20, 20, 0, 4, 3, -1);
    do_fill("offx", 1'b0, 1'b1, 200, 10, 4, 4, 1, -1);
    do_fill("both", 1'b1, 1'b1, 30, 30, 2, 2, 6, 100);

    // Reset in the middle of a 20x20 fill.
    @(negedge CLOCK_50);
    start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd20; h = 7'd20; colour_in = 3'd7;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("mid_plot", 32'(plot), 1);
    resetn = 1'b0;
    #1;
    chk("arst_plot", 32'(plot), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_x", 32'(x), 0);
    chk("arst_y", 32'(y), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    errs = 0;
    repeat (30) begin
      @(negedge CLOCK_50);
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("arst_quiet", errs, 0);
    do_fill("one", 1'b0, 1'b1, 0, 0, 1, 1, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rect_fill_ctrl.md
RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 160, meaning visible pixel columns.
REQ-002 The block SHALL have parameter SCREEN_H, default 120, meaning visible pixel rows.
REQ-003 The block SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request to fill the rectangle given by x0/y0/w/h.
REQ-006 The block SHALL have port clear  input  1  request to fill the whole screen with colour_in.
REQ-007 The block SHALL have port x0  input  8  rectangle left column.
REQ-008 The block SHALL have port y0  input  7  rectangle top row.
REQ-009 The block SHALL have port w  input  8  rectangle width in pixels.
REQ-010 The block SHALL have port h  input  7  rectangle height in pixels.
REQ-011 The block SHALL have port colour_in  input  3  fill colour (R,G,B, 1 bit each).
REQ-012 The block SHALL have port x  output  8  pixel column to the VGA adapter.
REQ-013 The block SHALL have port y  output  7  pixel row to the VGA adapter.
REQ-014 The block SHALL have port colour  output  3  pixel colour to the VGA adapter.
REQ-015 The block SHALL have port plot  output  1  write strobe to the VGA adapter; one pixel per high cycle.
REQ-016 The block SHALL have port busy  output  1  high while a fill is in progress.
REQ-017 The block SHALL have port done  output  1  one-cycle pulse at fill completion.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DRAW and FINISH.
REQ-019 In IDLE, a clock edge with clear=1 SHALL latch x0=0, y0=0, w=SCREEN_W, h=SCREEN_H and colour_in, then go to LOAD; clear SHALL win if start is also 1.
REQ-020 In IDLE, a clock edge with start=1 and clear=0 SHALL latch x0, y0, w, h and colour_in, then go to LOAD.
REQ-021 start and clear SHALL be ignored in every state other than IDLE, with no queuing.
REQ-022 LOAD SHALL compute the clipped end coordinates in 9-bit arithmetic: xe = min(x0+w, SCREEN_W)-1 and ye = min(y0+h, SCREEN_H)-1.
REQ-023 LOAD SHALL go to FINISH, with no plots, if w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H; otherwise it SHALL set x=x0, y=y0 and go to DRAW.
REQ-024 In DRAW, plot SHALL be 1 every cycle, colour SHALL equal the latched colour, and exactly one pixel SHALL be emitted per cycle.
REQ-025 Scan order SHALL be raster: x increments each cycle; at x=xe, x reloads x0 and y increments; at x=xe and y=ye, the state goes to FINISH.
REQ-026 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in LOAD, DRAW and FINISH, and 0 in IDLE.
REQ-028 Latency SHALL be: request sampled at edge N; LOAD in cycle N+1; first plot in cycle N+2; done one cycle after the last plot.
REQ-029 Total plot cycles SHALL equal (xe-x0+1)*(ye-y0+1), and never any pixel outside the screen.
REQ-030 Input changes after the latch edge SHALL NOT affect the fill in progress.
REQ-031 plot SHALL be 0 in every state except DRAW.

Reset
REQ-032 When resetn=0, the block SHALL immediately enter IDLE and drive x=0, y=0, colour=0, plot=0, busy=0 and done=0, independent of the clock.
REQ-033 Reset asserted mid-fill SHALL abort the fill with no further plots and no done pulse; after release, the block SHALL accept a new request on the next edge.

Verification
REQ-034 start, x0=10, y0=5, w=3, h=2, colour_in=3'b100 -> 6 plots at (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) with colour 100, first plot 2 cycles after the request, then one done pulse.
REQ-035 clear, colour_in=3'b000 -> 19200 consecutive plot cycles covering (0,0)..(159,119), then done; busy high for 19202 cycles.
REQ-036 start, x0=158, y0=118, w=5, h=5 -> 4 plots only, at (158,118)(159,118)(158,119)(159,119); start with w=0 -> no plots, and done 2 cycles after the request.
REQ-037 start and clear together in IDLE -> full-screen fill; a second start pulse during DRAW -> ignored, with no extra plots after done.
REQ-038 resetn low for 1 cycle during DRAW of a 20x20 fill -> plot and busy fall immediately, no done pulse; a new start of 1x1 at (0,0) -> 1 plot, then done.
